// File: rtl/tik_countdown.sv
// Tick-driven countdown stage with load/edit/pause control and borrow/done outputs.
// Optional periodic mode: define TIK_COUNTDOWN_AUTO_RELOAD_EN to reload on expiry.
module tik_countdown #(
  parameter int MAX_COUNT = 100,
  parameter int WIDTH     = $clog2(MAX_COUNT),
  parameter int INIT_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             up,
  input  logic             dn,
  input  logic             i_tik,
  input  logic             i_zero_hi,
  output logic [WIDTH-1:0] o_time,
  output logic             o_zero,
  output logic             o_borrow,
  output logic             o_done,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] MAX_M1  = WIDTH'(MAX_COUNT - 1);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH-1:0] INIT_V  = WIDTH'(INIT_VAL);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             borrow_q, borrow_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] load_sat;
  logic             edit;

`ifdef TIK_COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  assign load_sat = ({1'b0, load_val} >= MAX_EXT) ? MAX_M1 : load_val;
  assign edit     = load | dn | up;

  // Combinational so a chain of stages resolves "everything above me is zero" in one cycle.
  assign o_zero   = (count_q == '0) & i_zero_hi;
  assign o_time   = count_q;
  assign o_borrow = borrow_q;
  assign o_done   = done_q;
  assign o_busy   = (state_q == RUN);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    count_d  = count_q;
    borrow_d = 1'b0;
    done_d   = 1'b0;
`ifdef TIK_COUNTDOWN_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif

    if (clr) begin
      state_d = IDLE;
      count_d = INIT_V;
`ifdef TIK_COUNTDOWN_AUTO_RELOAD_EN
      reload_d = INIT_V;
`endif
    end else if (state_q == RUN) begin
      // A tick arriving with pause is deliberately dropped.
      if (pause) begin
        state_d = PAUSE;
      end else if (i_tik) begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else if (!i_zero_hi) begin
          count_d  = MAX_M1;
          borrow_d = 1'b1;
        end else begin
          done_d = 1'b1;
`ifdef TIK_COUNTDOWN_AUTO_RELOAD_EN
          count_d = reload_q;
`else
          state_d = DONE;
`endif
        end
      end
    end else begin
      if (load) begin
        count_d = load_sat;
`ifdef TIK_COUNTDOWN_AUTO_RELOAD_EN
        reload_d = load_sat;
`endif
      end else if (dn) begin
        count_d = (count_q == '0) ? MAX_M1 : count_q - 1'b1;
      end else if (up) begin
        count_d = (count_q == MAX_M1) ? '0 : count_q + 1'b1;
      end else if (start && !o_zero) begin
        state_d = RUN;
      end
      if (edit && state_q == DONE) state_d = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= INIT_V;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
    end
  end

`ifdef TIK_COUNTDOWN_AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reload_q <= INIT_V;
    else        reload_q <= reload_d;
  end
`endif

endmodule

// File: tb/tb_tik_countdown.sv
// Self-checking bench for tik_countdown (MAX_COUNT=10): vector table plus corner sequences,
// with expected outputs queued on drive and compared one cycle later.
module tb_tik_countdown;

  localparam int MAXC = 10;
  localparam int W    = $clog2(MAXC);
`ifdef TIK_COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr, load, start, pause, up, dn, i_tik, i_zero_hi;
  logic [W-1:0] load_val;
  logic [W-1:0] o_time;
  logic         o_zero, o_borrow, o_done, o_busy;

  tik_countdown #(.MAX_COUNT(MAXC), .INIT_VAL(0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .up(up), .dn(dn), .i_tik(i_tik),
    .i_zero_hi(i_zero_hi), .o_time(o_time), .o_zero(o_zero),
    .o_borrow(o_borrow), .o_done(o_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic clr, load;
    logic [W-1:0] lv;
    logic start, pause, up, dn, tik, zh;
    logic [W-1:0] t;
    logic b, d, busy;
  } vec_t;

  typedef struct {
    logic [W-1:0] t;
    logic b, d, busy, z;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic vec_t v(logic c, logic l, int lv, logic s, logic p, logic u, logic d_,
                             logic tk, logic zh, int t, logic b, logic d, logic busy);
    vec_t r;
    r.clr = c; r.load = l; r.lv = W'(lv); r.start = s; r.pause = p; r.up = u; r.dn = d_;
    r.tik = tk; r.zh = zh; r.t = W'(t); r.b = b; r.d = d; r.busy = busy;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic apply(input vec_t x, input string tag);
    exp_t e;
    clr = x.clr; load = x.load; load_val = x.lv; start = x.start; pause = x.pause;
    up = x.up; dn = x.dn; i_tik = x.tik; i_zero_hi = x.zh;
    sb.push_back('{t: x.t, b: x.b, d: x.d, busy: x.busy, z: (x.t == '0) & x.zh});
    @(negedge clk);
    e = sb.pop_front();
    check({tag, " time"},   32'(o_time),   32'(e.t));
    check({tag, " borrow"}, 32'(o_borrow), 32'(e.b));
    check({tag, " done"},   32'(o_done),   32'(e.d));
    check({tag, " busy"},   32'(o_busy),   32'(e.busy));
    check({tag, " zero"},   32'(o_zero),   32'(e.z));
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 0; load = 0; load_val = '0; start = 0; pause = 0; up = 0; dn = 0;
    i_tik = 0; i_zero_hi = 1;

    //        clr ld lv st pa up dn tk zh  t  b  d  busy
    tbl.push_back(v(0, 1, 3, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0));            // load 3
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 1));            // start
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, AR ? 3 : 0, 0, 1, AR));  // expiry
    tbl.push_back(v(0, 1, 3, 0, 0, 0, 0, 0, 1, 3, 0, 0, AR));           // load: DONE->IDLE or ignored in RUN
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));            // clr
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));            // start at zero ignored
    tbl.push_back(v(0, 1, 15, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0));           // load saturates
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));            // up wraps 9->0
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 1, 9, 0, 0, 0));            // dn wraps 0->9
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 1, 8, 0, 0, 0));
    tbl.push_back(v(0, 1, 4, 1, 0, 1, 1, 0, 1, 4, 0, 0, 0));            // load beats dn/up/start
    tbl.push_back(v(0, 0, 0, 1, 0, 1, 1, 0, 1, 3, 0, 0, 0));            // dn beats up/start
    tbl.push_back(v(0, 0, 0, 1, 0, 1, 0, 0, 1, 4, 0, 0, 0));            // up beats start
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 4, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, 1, 3, 0, 0, 0));            // pause drops tick
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0));            // tick in PAUSE ignored
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 1));            // resume
    tbl.push_back(v(0, 1, 7, 0, 0, 1, 1, 0, 1, 3, 0, 0, 1));            // edits ignored in RUN
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 9, 1, 0, 1));            // borrow wrap
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 1));            // borrow lasts 1 cycle
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0));            // clr beats pause/tick
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));            // start at 0, upper nonzero
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 9, 1, 0, 1));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));            // start at zero from IDLE
    tbl.push_back(v(0, 1, 5, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0));
    tbl.push_back(v(1, 1, 6, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));            // clr beats load

    repeat (2) @(negedge clk);
    check("reset time",   32'(o_time),   0);
    check("reset busy",   32'(o_busy),   0);
    check("reset done",   32'(o_done),   0);
    check("reset borrow", 32'(o_borrow), 0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

`ifdef TIK_COUNTDOWN_AUTO_RELOAD_EN
    apply(v(0, 1, 2, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0), "ar load");
    apply(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 1), "ar start");
    apply(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1), "ar tik1");
    apply(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1), "ar tik2");
    apply(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 1, 1), "ar expiry");
    apply(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1), "ar rerun");
`else
    apply(v(0, 1, 5, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0), "run load");
    apply(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 1), "run start");
    apply(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 0, 0, 1), "run tik");
`endif

    // Asynchronous reset in the middle of a run, asserted away from any clock edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst time",   32'(o_time),   0);
    check("midrst busy",   32'(o_busy),   0);
    check("midrst done",   32'(o_done),   0);
    check("midrst borrow", 32'(o_borrow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), "post rst idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
